// File: rtl/rfid_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rfid_pkg
// Purpose : Shared types and constants for the RFID reply deframer:
//           FSM state encoding, Gen2 CRC-16 constants, default preamble and
//           the single-bit CRC step used by the serial CRC engine.
// Revision: 1.0 - initial release
// ============================================================================
package rfid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HUNT = 3'd1,
        ST_DATA = 3'd2,
        ST_CRC  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [15:0] CRC16_POLY       = 16'h1021;
    localparam logic [15:0] CRC16_PRESET     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE    = 16'h1D0F;
    localparam logic [11:0] PREAMBLE_DEFAULT = 12'b110100100011;

    // One MSB-first shift of the CRC-16/CCITT register.
    function automatic logic [15:0] crc16_comb(input logic [15:0] crc,
                                               input logic        bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rfid_frame_deframer_if.sv
`default_nettype none
// ============================================================================
// Module  : rfid_frame_deframer_if
// Purpose : Bit-stream input and frame-output handshake bundle.
// Ports   : in_valid/in_bit          - decoded bit strobe and value
//           out_valid/out_ready      - frame handshake
//           out_data/out_crc/out_crc_ok - frame payload and CRC verdict
//           master modport = deframer side, slave modport = environment.
// Revision: 1.0 - initial release
// ============================================================================
interface rfid_frame_deframer_if #(
    parameter int DATA_BITS = 16
);
    logic                 in_valid;
    logic                 in_bit;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_BITS-1:0] out_data;
    logic [15:0]          out_crc;
    logic                 out_crc_ok;

    modport master (
        input  in_valid, in_bit, out_ready,
        output out_valid, out_data, out_crc, out_crc_ok
    );

    modport slave (
        output in_valid, in_bit, out_ready,
        input  out_valid, out_data, out_crc, out_crc_ok
    );
endinterface
`default_nettype wire

// File: rtl/crc16_serial.sv
`default_nettype none
// ============================================================================
// Module  : crc16_serial
// Purpose : Serial MSB-first CRC-16/CCITT register (poly 0x1021).
// Ports   : sys_clk, rst - clock and synchronous active-high reset
//           init         - load the 0xFFFF preset (wins over en)
//           en, bit_in   - shift one bit into the CRC
//           crc          - current register value
// Revision: 1.0 - initial release
// ============================================================================
module crc16_serial
    import rfid_pkg::*;
(
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] r_crc;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_crc <= 16'h0000;
        end else if (init) begin
            r_crc <= CRC16_PRESET;
        end else if (en) begin
            r_crc <= crc16_comb(r_crc, bit_in);
        end
    end

    assign crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/rfid_frame_deframer.sv
`default_nettype none
// ============================================================================
// Module  : rfid_frame_deframer
// Purpose : Hunts for the reply preamble in a decoded bit stream, captures
//           DATA_BITS data bits plus a 16-bit CRC, verifies the Gen2 CRC-16
//           and presents the frame under a valid/ready handshake.
// Ports   : sys_clk, rst  - clock, synchronous active-high reset
//           enable        - arms the deframer; low returns to IDLE
//           bus (master)  - bit input and frame output handshake
//           busy          - frame reception in progress (DATA/CRC)
//           err_timeout   - pulse: frame aborted on inter-bit timeout
//           err_overrun   - pulse: bit dropped while a frame is pending
// Revision: 1.0 - initial release
// ============================================================================
module rfid_frame_deframer
    import rfid_pkg::*;
#(
    parameter int          DATA_BITS = 16,
    parameter logic [11:0] PREAMBLE  = PREAMBLE_DEFAULT,
    parameter int          TIMEOUT   = 4096
)(
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 enable,
    rfid_frame_deframer_if.master bus,
    output logic                 busy,
    output logic                 err_timeout,
    output logic                 err_overrun
);

    localparam int c_IDLE_W = $clog2(TIMEOUT + 1);

    state_t               r_state;
    logic [11:0]          r_shreg;
    logic [3:0]           r_fill;
    logic [7:0]           r_cnt;
    logic [c_IDLE_W-1:0]  r_idle;
    logic [DATA_BITS-1:0] r_data;
    logic [15:0]          r_crc_rx;
    logic                 r_out_valid;
    logic                 r_crc_ok;
    logic                 r_busy;
    logic                 r_err_timeout;
    logic                 r_err_overrun;

    logic [11:0] w_shreg_next;
    logic [3:0]  w_fill_next;
    logic        w_match;
    logic        w_in_frame;
    logic        w_crc_init;
    logic        w_crc_en;
    logic        w_timeout_hit;
    logic [15:0] w_crc;
    logic [15:0] w_crc_next;

    always_comb begin
        w_shreg_next  = {r_shreg[10:0], bus.in_bit};
        w_fill_next   = (r_fill == 4'd12) ? 4'd12 : r_fill + 4'd1;
        w_match       = enable && (r_state == ST_HUNT) && bus.in_valid &&
                        (w_fill_next == 4'd12) && (w_shreg_next == PREAMBLE);
        w_in_frame    = (r_state == ST_DATA) || (r_state == ST_CRC);
        w_crc_init    = !enable || (r_state == ST_IDLE) || w_match;
        w_crc_en      = enable && w_in_frame && bus.in_valid;
        // CRC value including the bit on the bus, used for the final verdict.
        w_crc_next    = crc16_comb(w_crc, bus.in_bit);
        w_timeout_hit = w_in_frame && !bus.in_valid &&
                        (r_idle == c_IDLE_W'(TIMEOUT - 1));
    end

    crc16_serial u_crc (
        .sys_clk (sys_clk),
        .rst     (rst),
        .init    (w_crc_init),
        .en      (w_crc_en),
        .bit_in  (bus.in_bit),
        .crc     (w_crc)
    );

    always_ff @(posedge sys_clk) begin
        r_err_timeout <= 1'b0;
        r_err_overrun <= 1'b0;
        if (rst || !enable) begin
            // Reset and disable both discard everything, pending frame included.
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            r_fill      <= '0;
            r_cnt       <= '0;
            r_idle      <= '0;
            r_data      <= '0;
            r_crc_rx    <= '0;
            r_out_valid <= 1'b0;
            r_crc_ok    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_HUNT;

                ST_HUNT: begin
                    if (bus.in_valid) begin
                        r_shreg <= w_shreg_next;
                        r_fill  <= w_fill_next;
                    end
                    if (w_match) begin
                        r_state <= ST_DATA;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_idle  <= '0;
                    end
                end

                ST_DATA, ST_CRC: begin
                    if (bus.in_valid) begin
                        r_idle <= '0;
                        if (r_state == ST_DATA) begin
                            r_data <= (r_data << 1) | DATA_BITS'(bus.in_bit);
                            if (r_cnt == 8'(DATA_BITS - 1)) begin
                                r_cnt   <= '0;
                                r_state <= ST_CRC;
                            end else begin
                                r_cnt <= r_cnt + 8'd1;
                            end
                        end else begin
                            r_crc_rx <= {r_crc_rx[14:0], bus.in_bit};
                            if (r_cnt == 8'd15) begin
                                r_state     <= ST_DONE;
                                r_out_valid <= 1'b1;
                                r_busy      <= 1'b0;
                                r_crc_ok    <= (w_crc_next == CRC16_RESIDUE);
                            end else begin
                                r_cnt <= r_cnt + 8'd1;
                            end
                        end
                    end else if (w_timeout_hit) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= ST_HUNT;
                        r_busy        <= 1'b0;
                        r_shreg       <= '0;
                        r_fill        <= '0;
                        r_idle        <= '0;
                    end else begin
                        r_idle <= r_idle + 1'b1;
                    end
                end

                ST_DONE: begin
                    if (bus.in_valid) begin
                        r_err_overrun <= 1'b1;
                    end
                    if (r_out_valid && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_HUNT;
                        r_shreg     <= '0;
                        r_fill      <= '0;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_data;
    assign bus.out_crc    = r_crc_rx;
    assign bus.out_crc_ok = r_crc_ok;
    assign busy           = r_busy;
    assign err_timeout    = r_err_timeout;
    assign err_overrun    = r_err_overrun;

endmodule
`default_nettype wire

// File: tb/tb_rfid_frame_deframer.sv
`default_nettype none
// ============================================================================
// Module  : tb_rfid_frame_deframer
// Purpose : Self-checking bench for rfid_frame_deframer (DATA_BITS = 72).
//           Expected frames go into a queue as they are sent; a monitor pops
//           and compares whenever the DUT presents a new frame.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rfid_frame_deframer;
    import rfid_pkg::*;

    localparam int          DB       = 72;
    localparam logic [71:0] c_DATA   = 72'h313233343536373839;
    localparam logic [15:0] c_CRC    = 16'hD64E;
    localparam logic [71:0] c_FLIP   = c_DATA ^ (72'd1 << (71 - 5));
    localparam logic [11:0] c_PRE    = 12'b110100100011;

    typedef struct packed {
        logic [71:0] data;
        logic [15:0] crc;
        logic        ok;
    } frame_t;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic busy, err_timeout, err_overrun;

    rfid_frame_deframer_if #(.DATA_BITS(DB)) bus ();

    rfid_frame_deframer #(.DATA_BITS(DB), .PREAMBLE(c_PRE), .TIMEOUT(4096)) dut (
        .sys_clk     (clk),
        .rst         (rst),
        .enable      (enable),
        .bus         (bus),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    frame_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int n_timeout = 0;
    int n_overrun = 0;
    int n_frames = 0;
    logic seen = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: counts error pulses, scores each newly presented frame.
    always @(negedge clk) begin
        frame_t e;
        if (err_timeout) n_timeout++;
        if (err_overrun) n_overrun++;
        if (bus.out_valid && !seen) begin
            seen = 1'b1;
            n_frames++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame: got data %0h crc %0h expected no frame",
                         bus.out_data, bus.out_crc);
            end else begin
                e = exp_q.pop_front();
                chk("frame_data", bus.out_data, e.data);
                chk("frame_crc", bus.out_crc, e.crc);
                chk("frame_crc_ok", bus.out_crc_ok, e.ok);
            end
        end else if (!bus.out_valid) begin
            seen = 1'b0;
        end
    end

    // Caller is at a negedge; returns at the next negedge.
    task automatic send_bit(input logic b);
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [127:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_frame(input logic [71:0] d, input logic [15:0] c);
        send_bits(128'(c_PRE), 12);
        send_bits(128'(d), 72);
        send_bits(128'(c), 16);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_data"}, bus.out_data, 0);
        chk({tag, "_out_crc"}, bus.out_crc, 0);
        chk({tag, "_out_crc_ok"}, bus.out_crc_ok, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int t0;
        int o0;
        rst = 1'b1;
        enable = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_bit = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        chk("reset_err_timeout", err_timeout, 0);
        chk("reset_err_overrun", err_overrun, 0);

        rst = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        chk("idle_to_hunt", dut.r_state, ST_HUNT);

        // Good frame with latency/busy checks.
        exp_q.push_back('{c_DATA, c_CRC, 1'b1});
        send_bits(128'(c_PRE), 12);
        chk("busy_after_match", busy, 1);
        send_bits(128'(c_DATA), 72);
        send_bits(128'(c_CRC), 16);
        chk("latency_out_valid", bus.out_valid, 1);
        chk("busy_done", busy, 0);
        @(negedge clk);

        // Corrupted data bit 5.
        exp_q.push_back('{c_FLIP, c_CRC, 1'b0});
        send_frame(c_FLIP, c_CRC);
        @(negedge clk);

        // Preamble-free filler, then overlapped preamble prefix.
        send_bits(128'(40'hAAAAAAAAAA), 40);
        chk("no_false_match", busy, 0);
        send_bits(128'(15'b110110100100011), 15);
        chk("aligned_match", busy, 1);
        exp_q.push_back('{c_DATA, c_CRC, 1'b1});
        send_bits(128'(c_DATA), 72);
        send_bits(128'(c_CRC), 16);
        @(negedge clk);

        // Timeout after data bit 7.
        t0 = n_timeout;
        send_bits(128'(c_PRE), 12);
        send_bits(128'(c_DATA[71:64]), 8);
        repeat (4100) @(negedge clk);
        chk("timeout_pulses", n_timeout - t0, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_no_valid", bus.out_valid, 0);
        exp_q.push_back('{c_DATA, c_CRC, 1'b1});
        send_frame(c_DATA, c_CRC);
        @(negedge clk);

        // Back-pressure with overrun bits.
        bus.out_ready = 1'b0;
        exp_q.push_back('{c_FLIP, c_CRC, 1'b0});
        send_frame(c_FLIP, c_CRC);
        o0 = n_overrun;
        for (int c = 0; c < 50; c++) begin
            if (c == 10 || c == 20 || c == 30) send_bit(1'b1);
            else @(negedge clk);
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_data", bus.out_data, c_FLIP);
        end
        chk("overrun_pulses", n_overrun - o0, 3);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("handshake_valid_fall", bus.out_valid, 0);
        chk("handshake_state", dut.r_state, ST_HUNT);
        chk("handshake_data_kept", bus.out_data, c_FLIP);

        // Enable drop mid-DATA.
        send_bits(128'(c_PRE), 12);
        send_bits(128'(c_DATA[71:52]), 20);
        chk("enable_busy_before", busy, 1);
        enable = 1'b0;
        @(negedge clk);
        chk_reset_outputs("enable_drop");
        chk("enable_drop_state", dut.r_state, ST_IDLE);
        enable = 1'b1;
        @(negedge clk);

        // Reset mid-CRC.
        send_bits(128'(c_PRE), 12);
        send_bits(128'(c_DATA), 72);
        send_bits(128'(c_CRC[15:8]), 8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("rst_mid_crc");
        @(negedge clk);

        // Recovery frame.
        exp_q.push_back('{c_DATA, c_CRC, 1'b1});
        send_frame(c_DATA, c_CRC);
        repeat (5) @(negedge clk);
        chk("frame_count", n_frames, 6);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
